// File: rtl/screenchar_field_writer.sv
// Refreshes NUM_FIELDS decimal fields plus one terminal line into screen memory through one write port.
// Optional build macro LEADING_BLANK_EN: blank leading zero digits instead of zero-padding.
module screenchar_field_writer #(
   parameter int NUM_FIELDS = 2,
   parameter int DIGITS     = 4,
   parameter int VALUE_W    = 32,
   parameter int ADDR_W     = 8,
   parameter int TERM_LEN   = 32
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NUM_FIELDS*VALUE_W-1:0] field_value,
   input  logic [NUM_FIELDS*ADDR_W-1:0]  field_base,
   input  logic [ADDR_W-1:0]             term_base,
   input  logic [8*TERM_LEN-1:0]         ps2_line_content,
   input  logic                          ps2_line_ready,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [7:0]                    wr_data,
   output logic                          pass_done
);

   // state   | meaning
   // S_LOAD  | snapshot value/base of current field
   // S_DIV   | restoring divide by 10, VALUE_W cycles per digit
   // S_WRITE | write DIGITS characters, LS digit first
   // S_TERM  | write TERM_LEN characters of the active line
   // S_DONE  | one-cycle end-of-pass strobe
   typedef enum logic [2:0] {S_LOAD, S_DIV, S_WRITE, S_TERM, S_DONE} state_t;

   localparam int FLD_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int TERM_W = (TERM_LEN > 1) ? $clog2(TERM_LEN) : 1;
   localparam int BIT_W  = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

   state_t                       state_q, state_d;
   logic [FLD_W-1:0]             fld_q, fld_d;
   logic [VALUE_W-1:0]           dvd_q, dvd_d;
   logic [3:0]                   rem_q, rem_d;
   logic [BIT_W-1:0]             bit_q, bit_d;
   logic [DIG_W-1:0]             dig_q, dig_d;
   logic [DIGITS-1:0][3:0]       digits_q, digits_d;
   logic                         ovf_q, ovf_d;
   logic [ADDR_W-1:0]            base_q, base_d;
   logic [ADDR_W-1:0]            tbase_q, tbase_d;
   logic [TERM_W-1:0]            tcnt_q, tcnt_d;
   logic [TERM_LEN-1:0][7:0]     shadow_q, shadow_d;
   logic [TERM_LEN-1:0][7:0]     active_q, active_d;
   logic                         pending_q, pending_d;
   logic [ADDR_W-1:0]            last_addr_q, last_addr_d;
   logic [7:0]                   last_data_q, last_data_d;

   logic [VALUE_W-1:0]           val_sel;
   logic [ADDR_W-1:0]            fbase_sel;
   logic [4:0]                   trial;
   logic                         ge;
   logic [3:0]                   rem_nx;
   logic [VALUE_W-1:0]           dvd_nx;
   logic                         lead_blank;
   logic [7:0]                   digit_ch;

   always_comb begin
      val_sel   = '0;
      fbase_sel = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (fld_q == FLD_W'(i)) begin
            val_sel   = field_value[i*VALUE_W +: VALUE_W];
            fbase_sel = field_base[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Dividend shifts left in place; after VALUE_W steps it holds the quotient.
   assign trial  = {rem_q, dvd_q[VALUE_W-1]};
   assign ge     = (trial >= 5'd10);
   assign rem_nx = ge ? 4'(trial - 5'd10) : trial[3:0];
   assign dvd_nx = (dvd_q << 1) | VALUE_W'(ge);

`ifdef LEADING_BLANK_EN
   always_comb begin
      logic zero_hi;
      zero_hi    = 1'b1;
      lead_blank = 1'b0;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         zero_hi = zero_hi & (digits_q[d] == 4'd0);
         if ((dig_q == DIG_W'(d)) && zero_hi) lead_blank = 1'b1;
      end
   end
`else
   assign lead_blank = 1'b0;
`endif

   always_comb begin
      digit_ch = {4'h3, digits_q[dig_q]};
      if (ovf_q)           digit_ch = 8'h23;
      else if (lead_blank) digit_ch = 8'h20;
   end

   always_comb begin
      wr_en     = 1'b0;
      wr_addr   = last_addr_q;
      wr_data   = last_data_q;
      pass_done = (state_q == S_DONE);
      if (state_q == S_WRITE) begin
         wr_en   = 1'b1;
         wr_addr = base_q + ADDR_W'(DIGITS - 1) - ADDR_W'(dig_q);
         wr_data = digit_ch;
      end else if (state_q == S_TERM) begin
         wr_en   = 1'b1;
         wr_addr = tbase_q + ADDR_W'(tcnt_q);
         wr_data = active_q[tcnt_q];
      end
   end

   always_comb begin
      state_d     = state_q;
      fld_d       = fld_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      bit_d       = bit_q;
      dig_d       = dig_q;
      digits_d    = digits_q;
      ovf_d       = ovf_q;
      base_d      = base_q;
      tbase_d     = tbase_q;
      tcnt_d      = tcnt_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      pending_d   = pending_q;
      last_addr_d = wr_addr;
      last_data_d = wr_data;
      case (state_q)
         S_LOAD: begin
            dvd_d   = val_sel;
            base_d  = fbase_sel;
            tbase_d = term_base;
            rem_d   = '0;
            bit_d   = '0;
            dig_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_DIV;
         end
         S_DIV: begin
            dvd_d = dvd_nx;
            rem_d = rem_nx;
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_W'(VALUE_W - 1)) begin
               digits_d[dig_q] = rem_nx;
               rem_d           = '0;
               bit_d           = '0;
               if (dig_q == DIG_W'(DIGITS - 1)) begin
                  ovf_d   = (dvd_nx != '0);
                  dig_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  dig_d = dig_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (dig_q == DIG_W'(DIGITS - 1)) begin
               dig_d = '0;
               if (fld_q == FLD_W'(NUM_FIELDS - 1)) begin
                  fld_d = '0;
                  if (pending_q) begin
                     active_d  = shadow_q;
                     pending_d = 1'b0;
                     tcnt_d    = '0;
                     state_d   = S_TERM;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  fld_d   = fld_q + 1'b1;
                  state_d = S_LOAD;
               end
            end else begin
               dig_d = dig_q + 1'b1;
            end
         end
         S_TERM: begin
            if (tcnt_q == TERM_W'(TERM_LEN - 1)) state_d = S_DONE;
            else                                 tcnt_d  = tcnt_q + 1'b1;
         end
         S_DONE: begin
            fld_d   = '0;
            state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
      // A line arriving on the TERM-entry cycle overrides the clear so it is kept for the next pass.
      if (ps2_line_ready) begin
         shadow_d  = ps2_line_content;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_LOAD;
         fld_q       <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         bit_q       <= '0;
         dig_q       <= '0;
         digits_q    <= '0;
         ovf_q       <= 1'b0;
         base_q      <= '0;
         tbase_q     <= '0;
         tcnt_q      <= '0;
         shadow_q    <= {TERM_LEN{8'h20}};
         active_q    <= {TERM_LEN{8'h20}};
         pending_q   <= 1'b0;
         last_addr_q <= '0;
         last_data_q <= '0;
      end else begin
         state_q     <= state_d;
         fld_q       <= fld_d;
         dvd_q       <= dvd_d;
         rem_q       <= rem_d;
         bit_q       <= bit_d;
         dig_q       <= dig_d;
         digits_q    <= digits_d;
         ovf_q       <= ovf_d;
         base_q      <= base_d;
         tbase_q     <= tbase_d;
         tcnt_q      <= tcnt_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
      end
   end

endmodule

// File: tb/tb_screenchar_field_writer.sv
// Bench for screenchar_field_writer: decimal/line model feeds an expected-write queue checked every cycle.
module tb_screenchar_field_writer;

   logic          clock = 1'b0;
   logic          resetn;
   logic [63:0]   field_value;
   logic [15:0]   field_base;
   logic [7:0]    term_base;
   logic [255:0]  ps2_line_content;
   logic          ps2_line_ready;
   logic          wr_en;
   logic [7:0]    wr_addr;
   logic [7:0]    wr_data;
   logic          pass_done;

   screenchar_field_writer dut (
      .clock            (clock),
      .resetn           (resetn),
      .field_value      (field_value),
      .field_base       (field_base),
      .term_base        (term_base),
      .ps2_line_content (ps2_line_content),
      .ps2_line_ready   (ps2_line_ready),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .pass_done        (pass_done)
   );

   always #5 clock = ~clock;

   typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
   wr_t           exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            last_done_cyc = 0;
   bit            have_last = 1'b0;
   int            exp_period = 0;
   logic [255:0]  m_shadow = {32{8'h20}};
   bit            m_pending = 1'b0;

   task automatic check(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Model: plain decimal arithmetic on the value, LS digit written first at the rightmost address.
   task automatic push_field(input logic [31:0] val, input logic [7:0] base);
      longint q = val;
      longint p = 1;
      int     dg[4];
      bit     ovf;
      bit     blank;
      wr_t    w;
      for (int d = 0; d < 4; d++) begin
         dg[d] = int'(q % 10);
         q = q / 10;
      end
      ovf = (q != 0);
      for (int d = 0; d < 4; d++) begin
         blank = 1'b0;
`ifdef LEADING_BLANK_EN
         blank = (d > 0) && (longint'(val) < p);
`endif
         p = p * 10;
         w.a = base + 8'(3 - d);
         if (ovf)        w.d = 8'h23;
         else if (blank) w.d = 8'h20;
         else            w.d = 8'h30 + 8'(dg[d]);
         exp_q.push_back(w);
      end
   endtask

   task automatic push_pass();
      wr_t w;
      push_field(field_value[31:0],  field_base[7:0]);
      push_field(field_value[63:32], field_base[15:8]);
      if (m_pending) begin
         for (int k = 0; k < 32; k++) begin
            w.a = term_base + 8'(k);
            w.d = m_shadow[8*k +: 8];
            exp_q.push_back(w);
         end
         m_pending  = 1'b0;
         exp_period = 2 * 133 + 32 + 1;
      end else begin
         exp_period = 2 * 133 + 1;
      end
   endtask

   task automatic pulse_line(input string s);
      logic [255:0] v;
      for (int k = 0; k < 32; k++) v[8*k +: 8] = (k < s.len()) ? s[k] : 8'h20;
      ps2_line_content = v;
      ps2_line_ready   = 1'b1;
      m_shadow  = v;
      m_pending = 1'b1;
      @(posedge clock);
      #1 ps2_line_ready = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!pass_done && n < 400);
      check("pass_done_seen", longint'(pass_done), 1);
   endtask

   task automatic wait_first_write(output int n);
      n = 0;
      while (!wr_en && n < 300) begin
         @(posedge clock);
         #1 n++;
      end
   endtask

   // Waits for the end of the current pass, applies new inputs, and queues the next pass (ends #1 into its LOAD cycle).
   task automatic next_pass(input logic [31:0] v0, input logic [7:0] b0,
                            input logic [31:0] v1, input logic [7:0] b1, input string line);
      wait_done();
      field_value = {v1, v0};
      field_base  = {b1, b0};
      if (line.len() > 0) pulse_line(line);
      else begin
         @(posedge clock);
         #1;
      end
      push_pass();
   endtask

   task automatic check_write_at(input int cycles, input string nm, input logic [7:0] a, input logic [7:0] d);
      repeat (cycles) @(posedge clock);
      #1;
      check({nm, "_en"},   longint'(wr_en),   1);
      check({nm, "_addr"}, longint'(wr_addr), longint'(a));
      check({nm, "_data"}, longint'(wr_data), longint'(d));
   endtask

   always @(negedge clock) begin
      wr_t e;
      cyc++;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_write: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", longint'(wr_addr), longint'(e.a));
            check("wr_data", longint'(wr_data), longint'(e.d));
         end
      end
      if (pass_done) begin
         check("writes_left", longint'(exp_q.size()), 0);
         if (have_last) check("pass_period", longint'(cyc - last_done_cyc), longint'(exp_period));
         last_done_cyc = cyc;
         have_last     = 1'b1;
      end
   end

   initial begin
      int n;
      resetn           = 1'b0;
      ps2_line_ready   = 1'b0;
      ps2_line_content = {32{8'h20}};
      field_value      = {32'd9999, 32'd1234};
      field_base       = {8'h10, 8'h3C};
      term_base        = 8'h80;
      repeat (3) @(negedge clock);
      check("rst_wr_en",     longint'(wr_en),     0);
      check("rst_pass_done", longint'(pass_done), 0);
      check("rst_wr_addr",   longint'(wr_addr),   0);
      check("rst_wr_data",   longint'(wr_data),   0);
      push_pass();
      resetn = 1'b1;

      // Pass 1: 1234 at 0x3C, first write 129 cycles after LOAD, then consecutive.
      wait_first_write(n);
      check("first_write_latency", longint'(n), 129);
      check("p1_w0_addr", longint'(wr_addr), 8'h3F);
      check("p1_w0_data", longint'(wr_data), 8'h34);
      check_write_at(1, "p1_w1", 8'h3E, 8'h33);
      check_write_at(1, "p1_w2", 8'h3D, 8'h32);
      check_write_at(1, "p1_w3", 8'h3C, 8'h31);

      // Pass 2: zero, overflow, and a new terminal line.
      next_pass(32'd0, 8'h3C, 32'd12345, 8'h10, "HELLO");
      check_write_at(262, "p2_ovf", 8'h13, 8'h23);
      check_write_at(4, "p2_term_h", 8'h80, 8'h48);
      check_write_at(4, "p2_term_o", 8'h84, 8'h4F);
      check_write_at(1, "p2_term_sp", 8'h85, 8'h20);

      // Pass 3: no new line (TERM skipped), address wrap at 0xFE.
      next_pass(32'h0000_0007, 8'h3C, 32'd42, 8'hFE, "");
      check_write_at(262, "p3_wrap_ls", 8'h01, 8'h32);
      check_write_at(3, "p3_wrap_ms", 8'hFE, 8'h30);
      @(posedge clock);
      #1;
      check("p3_done_no_term", longint'(pass_done), 1);
      check("p3_done_wr_en",   longint'(wr_en),     0);

      // Pass 4: line "A" before the pass, line "B" on the TERM-entry cycle.
      next_pass(32'hFFFF_FFFF, 8'h3C, 32'd9999, 8'h10, "A");
      check_write_at(265, "p4_last_field", 8'h10, 8'h39);
      pulse_line("B");
      #0;
      check("p4_term_a_addr", longint'(wr_addr), 8'h80);
      check("p4_term_a_data", longint'(wr_data), 8'h41);

      // Pass 5: no pulse, the retained "B" is written.
      next_pass(32'd0, 8'h3C, 32'd9999, 8'h10, "");
`ifdef LEADING_BLANK_EN
      check_write_at(132, "p5_zero_ms", 8'h3C, 8'h20);
`else
      check_write_at(132, "p5_zero_ms", 8'h3C, 8'h30);
`endif
      check_write_at(134, "p5_term_b", 8'h80, 8'h42);

      // Pass 6: reset asserted mid-WRITE, then restart at field 0.
      next_pass(32'd42, 8'hFE, 32'd1, 8'h20, "");
      check_write_at(130, "p6_mid", 8'h00, 8'h34);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_wr_en",   longint'(wr_en),   0);
      check("async_rst_wr_addr", longint'(wr_addr), 0);
      check("async_rst_wr_data", longint'(wr_data), 0);
      exp_q.delete();
      have_last = 1'b0;
      m_pending = 1'b0;
      repeat (3) @(negedge clock);
      check("held_rst_pass_done", longint'(pass_done), 0);
      push_pass();
      resetn = 1'b1;
      wait_first_write(n);
      check("restart_latency", longint'(n), 129);
      check("restart_addr", longint'(wr_addr), 8'h01);
      check("restart_data", longint'(wr_data), 8'h32);
      wait_done();
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/screenchar_field_writer.md
Name: screenchar_field_writer

Overview:
Parametrised successor to the fixed velocity/angle screen-character writer. Continuously refreshes NUM_FIELDS unsigned numeric fields, each rendered as DIGITS ASCII decimal characters, plus one terminal text line, into the dual-port screen character memory through a single write port. Decimal conversion is sequential (shift-subtract divide by 10), so arbitrary VALUE_W is supported without a combinational converter. Instantiated in projectmain between the game/PS2 logic and screenchar_mem.

Parameters:
NUM_FIELDS, 2, number of numeric fields refreshed per pass
DIGITS, 4, characters per field
VALUE_W, 32, width of each field value (unsigned)
ADDR_W, 8, screen memory address width
TERM_LEN, 32, terminal line length in characters

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
field_value  in  NUM_FIELDS*VALUE_W  packed values; field i = [i*VALUE_W +: VALUE_W]
field_base  in  NUM_FIELDS*ADDR_W  packed leftmost-character address of field i
term_base  in  ADDR_W  address of terminal character 0
ps2_line_content  in  8*TERM_LEN  terminal text; char k = [8*k +: 8]
ps2_line_ready  in  1  one-cycle pulse: line content valid
wr_en  out  1  memory write strobe
wr_addr  out  ADDR_W  memory write address
wr_data  out  8  memory write character
pass_done  out  1  one-cycle pulse at end of each full refresh pass

Behaviour:
- Reset (async assert, sync release): wr_en=0, wr_addr=0, wr_data=0, pass_done=0, state=LOAD, field index=0, pending=0, shadow/active line buffers=all 0x20. Reset mid-pass aborts immediately; no further writes until released.
- States: LOAD -> DIV -> WRITE -> (next field: LOAD | last field: TERM if pending, else DONE) ; TERM -> DONE ; DONE -> LOAD (field 0).
- LOAD (1 cycle): snapshot field_value[i] into dividend; digit counter=0.
- DIV: restoring shift-subtract by 10, VALUE_W cycles per digit; remainder stored as digit d (d=0 is LS); quotient becomes next dividend. DIGITS*VALUE_W cycles total.
- Overflow: if final quotient after DIGITS divisions is nonzero, all DIGITS characters written as '#' (0x23).
- WRITE: DIGITS cycles, wr_en=1, LS digit first: digit d written to field_base[i]+DIGITS-1-d as 0x30+d; address arithmetic modulo 2^ADDR_W (wrap-around).
- Per-field latency: 1 + DIGITS*VALUE_W + DIGITS cycles (defaults: 133).
- Line capture: ps2_line_ready=1 in any state loads shadow buffer and sets pending. On TERM entry, shadow copied to active and pending cleared; capture in that same cycle lands in shadow and pending stays set (newest line wins, never lost).
- TERM: TERM_LEN cycles, wr_en=1, char k of active buffer to term_base+k (mod 2^ADDR_W).
- DONE: 1 cycle, wr_en=0, pass_done=1.
- wr_en=0 in LOAD, DIV, DONE; wr_addr/wr_data hold last value when wr_en=0.
- Inputs other than ps2_line_* only sampled at LOAD; changes mid-field affect next pass.

Optional Feature:
LEADING_BLANK_EN: when defined, leading zero digits replaced by space (0x20), LS digit always printed (value 0 -> "   0"); overflow still all '#'. When undefined, zero-padded ("0000").

Test Plan:
- field0=1234, base 0x3C, DIGITS=4 -> writes (0x3F,'4'),(0x3E,'3'),(0x3D,'2'),(0x3C,'1') in consecutive cycles; first write 129 cycles after LOAD.
- field1=12345, DIGITS=4 -> four writes of 0x23; field1=9999 -> "9999".
- field0=0 -> "0000" without macro, "   0" with LEADING_BLANK_EN; field0=0x00000007 VALUE_W=32 -> "0007".
- ps2_line_ready with "HELLO" (rest spaces), term_base 0x80 -> TERM writes 'H' at 0x80 ... 'O' at 0x84, 0x20 at 0x85..0x9F; next pass without new pulse skips TERM.
- Pulse ps2_line_ready with "A" then "B" on TERM-entry cycle -> this pass writes "A", next pass writes "B".
- field_base=0xFE, DIGITS=4, value 42 -> writes '2'@0x01,'4'@0x00,'0'@0xFF,'0'@0xFE; assert resetn low mid-WRITE -> wr_en=0 asynchronously, restart at field 0 LOAD.
